traffic_generator: RTL and testbench

Packet source for one mesh node: creates packets at a fixed injection period, buffers them in a 4-entry queue, and injects them into the router's Local input port using the same Req/Gnt/Full handshake the node collector uses on the router's Local output. It is the upstream counterpart of the collector. Each packet carries a destination, a per-source PacketID and the source ModuleID, so the downstream collector can log sender and ID.

---
 rtl/traffic_generator.sv | 162 ++++++++++++++++
 tb/tb_traffic_generator.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_generator.sv
`default_nettype none
// ============================================================================
// Module   : traffic_generator
// Brief    : Periodic packet source with a 4-entry queue feeding a router's
//            Local input over the Req/Gnt/Full handshake.
// Revision : 1.0
// ============================================================================
module traffic_generator #(
    parameter logic [5:0] routerID    = 6'b000_000,
    parameter logic [5:0] ModuleID    = 6'b000_000,
    parameter int         dataWidth   = 32,
    parameter int         dim         = 4,
    parameter int         INJ_PERIOD  = 8,
    parameter int         NUM_PACKETS = 16,
    parameter int         DEST_MODE   = 0,
    parameter logic [5:0] DEST_ID     = 6'b000_001,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 DnStrFull,
    input  logic                 GntDnStr,
    output logic [dataWidth-1:0] PacketOut,
    output logic                 ReqDnStr,
    output logic                 Done,
    output logic [9:0]           SentCount,
    output logic [9:0]           DropCount
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_REQ       = 2'd1;
    localparam logic [1:0]  c_GAP       = 2'd2;
    localparam logic [7:0]  c_SEED_MIX  = SEED ^ {2'b00, ModuleID};
    localparam logic [7:0]  c_LFSR_INIT = (c_SEED_MIX == 8'h00) ? 8'h01 : c_SEED_MIX;
    localparam logic [15:0] c_PER_LAST  = 16'(INJ_PERIOD - 1);
    localparam logic [10:0] c_NUM       = 11'(NUM_PACKETS);
    localparam logic [9:0]  c_SAT       = 10'd1023;

    logic [1:0]           r_state;
    logic [15:0]          r_periodCnt;
    logic [10:0]          r_genCount;
    logic [7:0]           r_lfsr;
    logic [dataWidth-1:0] r_mem [0:3];
    logic [1:0]           r_wrPtr;
    logic [1:0]           r_rdPtr;
    logic [2:0]           r_count;
    logic [dataWidth-1:0] r_pktOut;
    logic                 r_req;
    logic [9:0]           r_sent;
    logic [9:0]           r_drop;

    logic                 w_genEvent;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic [7:0]           w_lfsrNext;
    logic [2:0]           w_xRaw;
    logic [2:0]           w_x;
    logic [2:0]           w_y;
    logic [5:0]           w_dest;
    logic [dataWidth-1:0] w_pkt;

    assign w_genEvent = enable && (r_periodCnt == c_PER_LAST) && (r_genCount < c_NUM);
    assign w_pop      = (r_state == c_REQ) && GntDnStr;
    // A full queue still accepts the new packet when the head leaves this cycle.
    assign w_push     = w_genEvent && ((r_count != 3'd4) || w_pop);
    assign w_drop     = w_genEvent && !w_push;
    assign w_lfsrNext = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

    always_comb begin
        w_xRaw = 3'({29'd0, r_lfsr[5:3]} % 32'(dim));
        w_y    = 3'({29'd0, r_lfsr[2:0]} % 32'(dim));
        w_x    = w_xRaw;
        if ({w_xRaw, w_y} == routerID) begin
            w_x = 3'(({29'd0, w_xRaw} + 32'd1) % 32'(dim));
        end
        w_dest = (DEST_MODE == 0) ? DEST_ID : {w_x, w_y};
        w_pkt         = '0;
        w_pkt[31:26]  = w_dest;
        w_pkt[15:6]   = r_genCount[9:0];
        w_pkt[5:0]    = ModuleID;
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wrPtr] <= w_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_periodCnt <= '0;
            r_genCount  <= '0;
            r_lfsr      <= c_LFSR_INIT;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_pktOut    <= '0;
            r_req       <= 1'b0;
            r_sent      <= '0;
            r_drop      <= '0;
        end else begin
            if (enable) begin
                r_periodCnt <= (r_periodCnt == c_PER_LAST) ? 16'd0 : r_periodCnt + 16'd1;
            end
            if (w_genEvent) begin
                r_genCount <= r_genCount + 11'd1;
                r_lfsr     <= w_lfsrNext;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 2'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drop != c_SAT)) begin
                r_drop <= r_drop + 10'd1;
            end

            case (r_state)
                c_IDLE: begin
                    if ((r_count != 3'd0) && !DnStrFull) begin
                        r_state  <= c_REQ;
                        r_req    <= 1'b1;
                        r_pktOut <= r_mem[r_rdPtr];
                    end
                end
                c_REQ: begin
                    if (GntDnStr) begin
                        r_state <= c_GAP;
                        r_req   <= 1'b0;
                        if (r_sent != c_SAT) begin
                            r_sent <= r_sent + 10'd1;
                        end
                    end
                end
                c_GAP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign PacketOut = r_pktOut;
    assign ReqDnStr  = r_req;
    assign SentCount = r_sent;
    assign DropCount = r_drop;
    assign Done      = (r_genCount == c_NUM) && (r_count == 3'd0) && (r_state == c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_traffic_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_generator
// Brief    : Scoreboard bench for traffic_generator: fixed-destination,
//            back-pressure and random-destination instances on one clock.
// Revision : 1.0
// ============================================================================
module tb_traffic_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- instance F: fixed destination, short run ----------------
    logic        rstF = 1'b1, enF = 1'b0, fullF = 1'b0, gntF = 1'b0, agF = 1'b1;
    logic        reqF, doneF;
    logic [31:0] pktF;
    logic [9:0]  sentF, dropF;
    logic [31:0] sbF[$];

    traffic_generator #(
        .routerID(6'b000_000), .ModuleID(6'b000_011), .dataWidth(32), .dim(4),
        .INJ_PERIOD(4), .NUM_PACKETS(3), .DEST_MODE(0), .DEST_ID(6'b001_010), .SEED(8'hA5)
    ) uF (
        .clk(clk), .reset(rstF), .enable(enF), .DnStrFull(fullF), .GntDnStr(gntF),
        .PacketOut(pktF), .ReqDnStr(reqF), .Done(doneF), .SentCount(sentF), .DropCount(dropF)
    );

    // ---------------- instance Q: back-pressure / drops ----------------
    logic        rstQ = 1'b1, enQ = 1'b0, fullQ = 1'b1, gntQ = 1'b0, agQ = 1'b1;
    logic        reqQ, doneQ;
    logic [31:0] pktQ;
    logic [9:0]  sentQ, dropQ;
    logic [31:0] sbQ[$];

    traffic_generator #(
        .routerID(6'b000_000), .ModuleID(6'b000_101), .dataWidth(32), .dim(4),
        .INJ_PERIOD(2), .NUM_PACKETS(10), .DEST_MODE(0), .DEST_ID(6'b010_011), .SEED(8'hA5)
    ) uQ (
        .clk(clk), .reset(rstQ), .enable(enQ), .DnStrFull(fullQ), .GntDnStr(gntQ),
        .PacketOut(pktQ), .ReqDnStr(reqQ), .Done(doneQ), .SentCount(sentQ), .DropCount(dropQ)
    );

    // ---------------- instance R: random destinations ----------------
    localparam logic [5:0] R_MOD = 6'b000_111;
    localparam logic [5:0] R_RID = 6'b001_001;
    localparam int         R_INJ = 2;
    localparam int         R_NUM = 200;

    logic        rstR = 1'b1, enR = 1'b0, fullR = 1'b0, gntR = 1'b0;
    logic        reqR, doneR;
    logic [31:0] pktR;
    logic [9:0]  sentR, dropR;
    logic [31:0] sbR[$];

    traffic_generator #(
        .routerID(R_RID), .ModuleID(R_MOD), .dataWidth(32), .dim(4),
        .INJ_PERIOD(R_INJ), .NUM_PACKETS(R_NUM), .DEST_MODE(1), .DEST_ID(6'b000_001), .SEED(8'hA5)
    ) uR (
        .clk(clk), .reset(rstR), .enable(enR), .DnStrFull(fullR), .GntDnStr(gntR),
        .PacketOut(pktR), .ReqDnStr(reqR), .Done(doneR), .SentCount(sentR), .DropCount(dropR)
    );

    // Reference rules for random destinations, straight from the packet definition.
    function automatic logic [7:0] lfsrStep(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [5:0] rndDest(input logic [7:0] l);
        int x = int'(l[5:3]) % 4;
        int y = int'(l[2:0]) % 4;
        logic [2:0] xs;
        logic [2:0] ys;
        if (x == int'(R_RID[5:3]) && y == int'(R_RID[2:0])) x = (x + 1) % 4;
        xs = 3'(x);
        ys = 3'(y);
        return {xs, ys};
    endfunction

    // Reference model for R: tracks generation events, drops and queue occupancy.
    int          mGen = 0, mEn = 0, mOcc = 0, mDrop = 0, mSent = 0, mPushPop = 0;
    logic [7:0]  mLfsr = 8'hA5 ^ {2'b00, R_MOD};

    always @(negedge clk) begin : p_modelR
        int  occ;
        logic ev;
        logic [9:0] idv;
        if (rstR) begin
            mGen = 0; mEn = 0; mOcc = 0; mDrop = 0;
            mLfsr = 8'hA5 ^ {2'b00, R_MOD};
            if (mLfsr == 8'h00) mLfsr = 8'h01;
            sbR.delete();
        end else begin
            occ = mOcc - ((reqR && gntR) ? 1 : 0);
            ev  = enR && ((mEn % R_INJ) == R_INJ - 1) && (mGen < R_NUM);
            if (enR) mEn++;
            if (ev) begin
                idv = 10'(mGen);
                if (occ < 4) begin
                    sbR.push_back({rndDest(mLfsr), 10'd0, idv, R_MOD});
                    occ++;
                    if (mOcc == 4) mPushPop++;
                end else begin
                    mDrop++;
                end
                mLfsr = lfsrStep(mLfsr);
                mGen++;
            end
            mOcc = occ;
        end
    end

    // Monitors: pop the scoreboard whenever a grant completes a transfer.
    always @(negedge clk) begin : p_monF
        if (!rstF && reqF && gntF) begin
            if (sbF.size() == 0) check("F_unexpected_pkt", pktF, 32'hFFFF_FFFF);
            else check("F_pkt", pktF, sbF.pop_front());
        end
    end

    always @(negedge clk) begin : p_monQ
        if (!rstQ && reqQ && gntQ) begin
            if (sbQ.size() == 0) check("Q_unexpected_pkt", pktQ, 32'hFFFF_FFFF);
            else check("Q_pkt", pktQ, sbQ.pop_front());
        end
    end

    logic        pR = 1'b0, pG = 1'b0, pF = 1'b0, pRst = 1'b1;
    logic [31:0] pP = '0;

    always @(negedge clk) begin : p_monR
        if (!rstR) begin
            if (reqR && gntR) begin
                mSent++;
                check("R_dest_x_range", {31'd0, pktR[31:29] < 3'd4}, 32'd1);
                check("R_dest_y_range", {31'd0, pktR[28:26] < 3'd4}, 32'd1);
                check("R_dest_not_self", {31'd0, pktR[31:26] != R_RID}, 32'd1);
                if (sbR.size() == 0) check("R_unexpected_pkt", pktR, 32'hFFFF_FFFF);
                else check("R_pkt", pktR, sbR.pop_front());
            end
            if (!pRst) begin
                if (reqR && !pR) check("R_rise_while_full", {31'd0, pF}, 32'd0);
                if (pR && !pG) begin
                    check("R_hold_req", {31'd0, reqR}, 32'd1);
                    check("R_hold_pkt", pktR, pP);
                end
                if (pR && pG) check("R_fall_after_gnt", {31'd0, reqR}, 32'd0);
            end
        end
        pR = reqR; pG = gntR; pF = fullR; pP = pktR; pRst = rstR;
    end

    // Grant responders for F and Q: one-cycle pulse the cycle after Req rises.
    initial forever begin
        @(posedge clk); #1;
        gntF = agF && reqF && !gntF;
        gntQ = agQ && reqQ && !gntQ;
    end

    task automatic waitDoneF(input int limit);
        for (int t = 0; t < limit && !doneF; t++) @(negedge clk);
    endtask

    task automatic scnF();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("F_rst_pkt", pktF, 32'd0);
        check("F_rst_req", {31'd0, reqF}, 32'd0);
        check("F_rst_done", {31'd0, doneF}, 32'd0);
        check("F_rst_sent", {22'd0, sentF}, 32'd0);
        check("F_rst_drop", {22'd0, dropF}, 32'd0);
        sbF.push_back(32'h2800_0003);
        sbF.push_back(32'h2800_0043);
        sbF.push_back(32'h2800_0083);
        @(posedge clk); #1;
        rstF = 1'b0; enF = 1'b1;
        waitDoneF(200);
        check("F_done", {31'd0, doneF}, 32'd1);
        check("F_sent", {22'd0, sentF}, 32'd3);
        check("F_drop", {22'd0, dropF}, 32'd0);
        check("F_sb_left", sbF.size(), 32'd0);

        // Restart, then reset while the first request is outstanding.
        agF = 1'b0;
        @(posedge clk); #1 rstF = 1'b1;
        @(posedge clk); #1 rstF = 1'b0;
        for (int t = 0; t < 50 && !reqF; t++) @(negedge clk);
        check("F_req_seen", {31'd0, reqF}, 32'd1);
        rstF = 1'b1;
        @(negedge clk);
        check("F_midrst_pkt", pktF, 32'd0);
        check("F_midrst_req", {31'd0, reqF}, 32'd0);
        check("F_midrst_done", {31'd0, doneF}, 32'd0);
        check("F_midrst_sent", {22'd0, sentF}, 32'd0);
        check("F_midrst_drop", {22'd0, dropF}, 32'd0);
        sbF.push_back(32'h2800_0003);
        sbF.push_back(32'h2800_0043);
        sbF.push_back(32'h2800_0083);
        agF = 1'b1;
        @(posedge clk); #1 rstF = 1'b0;
        waitDoneF(200);
        check("F_done2", {31'd0, doneF}, 32'd1);
        check("F_sent2", {22'd0, sentF}, 32'd3);
        check("F_sb_left2", sbF.size(), 32'd0);
    endtask

    task automatic scnQ();
        repeat (3) @(posedge clk);
        #1 rstQ = 1'b0; enQ = 1'b1;
        repeat (40) begin
            @(negedge clk);
            check("Q_req_low_full", {31'd0, reqQ}, 32'd0);
        end
        check("Q_drop_full", {22'd0, dropQ}, 32'd6);
        check("Q_sent_full", {22'd0, sentQ}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            logic [9:0] id = 10'(i);
            sbQ.push_back({6'b010_011, 10'd0, id, 6'b000_101});
        end
        @(posedge clk); #1 fullQ = 1'b0;
        for (int t = 0; t < 200 && !doneQ; t++) @(negedge clk);
        check("Q_done", {31'd0, doneQ}, 32'd1);
        check("Q_sent", {22'd0, sentQ}, 32'd4);
        check("Q_drop", {22'd0, dropQ}, 32'd6);
        check("Q_sb_left", sbQ.size(), 32'd0);
    endtask

    task automatic scnR();
        repeat (3) @(posedge clk);
        #1 rstR = 1'b0;
        for (int n = 0; n < 4000 && mGen < R_NUM; n++) begin
            enR   = ($urandom % 10) != 0;
            fullR = ($urandom % 5) == 0;
            gntR  = reqR ? 1'($urandom % 2) : (($urandom % 8) == 0);
            @(posedge clk); #1;
        end
        enR = 1'b1; fullR = 1'b0;
        for (int n = 0; n < 2000 && !doneR; n++) begin
            gntR = reqR;
            @(posedge clk); #1;
        end
        gntR = 1'b0;
        @(negedge clk);
        check("R_gen_total", mGen, R_NUM);
        check("R_done", {31'd0, doneR}, 32'd1);
        check("R_sent", {22'd0, sentR}, 32'(mSent));
        check("R_drop", {22'd0, dropR}, 32'(mDrop));
        check("R_sb_left", sbR.size(), 32'd0);
        check("R_push_on_full_pop_seen", {31'd0, mPushPop > 0}, 32'd1);
    endtask

    initial begin
        fork
            scnF();
            scnQ();
            scnR();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
